// File: rtl/xclk_ctrl_pkg.sv
// Shared widths, reset default and FSM state encoding for the camera clock generator.
package xclk_ctrl_pkg;

  localparam int unsigned DIV_W    = 10;
  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned DEF_DIV  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PEND   = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/xclk_phase_cnt.sv
// Half-period counter and output toggle for xclk_ctrl.
// load restarts a phase at a given level; clear parks counter and output at 0.
module xclk_phase_cnt
  import xclk_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             load_i,
  input  logic             load_val_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             wrap_o,
  output logic             outclk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  assign wrap_o   = (cnt_q == div_i);
  assign outclk_o = out_q;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (load_i) begin
      cnt_d = '0;
      out_d = load_val_i;
    end else if (clear_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (run_i) begin
      if (wrap_o) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/xclk_ctrl.sv
// Camera clock generator with glitch-free reconfiguration: requests wait for the
// end of a low phase, then the new setting must produce a number of edges before stable.
module xclk_ctrl
  import xclk_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV   = DEF_DIV,
  parameter logic        DEFAULT_EN    = 1'b1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             outclk,
  output logic             busy,
  output logic             stable
);

  localparam int unsigned SC_W = SETTLE_W + 1;
  localparam logic [SC_W-1:0] SETTLE_TGT = SC_W'(SETTLE_CYCLES);

  state_e              state_q;
  logic [DIV_W-1:0]    act_div_q, pend_div_q;
  logic                act_en_q, pend_en_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                out_prev_q;

  logic            wrap, accept, safe, rise, run, clear;
  logic [SC_W-1:0] settle_inc;

  assign cfg_ready  = (state_q != ST_PEND);
  assign busy       = (state_q == ST_PEND) || (state_q == ST_SETTLE);
  assign stable     = (state_q == ST_RUN);
  assign accept     = cfg_valid & cfg_ready;
  assign safe       = (state_q == ST_PEND) & ~outclk & (wrap | ~act_en_q);
  assign rise       = outclk & ~out_prev_q;
  assign run        = act_en_q & (state_q != ST_IDLE);
  assign clear      = (state_q == ST_IDLE);
  assign settle_inc = {1'b0, settle_q} + SC_W'(1);

  xclk_phase_cnt u_phase (
    .clk        (in_clk),
    .reset      (reset),
    .run_i      (run),
    .load_i     (safe),
    .load_val_i (pend_en_q),
    .clear_i    (clear),
    .div_i      (act_div_q),
    .wrap_o     (wrap),
    .outclk_o   (outclk)
  );

  // Rising edges are counted one cycle late, so the edge made at the safe point is included.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q    <= DEFAULT_EN ? ST_SETTLE : ST_IDLE;
      act_div_q  <= DIV_W'(DEFAULT_DIV);
      act_en_q   <= DEFAULT_EN;
      pend_div_q <= '0;
      pend_en_q  <= 1'b0;
      settle_q   <= '0;
      out_prev_q <= 1'b0;
    end else begin
      out_prev_q <= outclk;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            pend_div_q <= cfg_div;
            pend_en_q  <= cfg_en;
            state_q    <= ST_PEND;
          end
        end
        ST_SETTLE: begin
          if (accept) begin
            pend_div_q <= cfg_div;
            pend_en_q  <= cfg_en;
            settle_q   <= '0;
            state_q    <= ST_PEND;
          end else if (rise) begin
            if (!settle_inc[SETTLE_W]) settle_q <= settle_inc[SETTLE_W-1:0];
            if (settle_inc >= SETTLE_TGT) state_q <= ST_RUN;
          end
        end
        ST_PEND: begin
          if (safe) begin
            act_div_q <= pend_div_q;
            act_en_q  <= pend_en_q;
            settle_q  <= '0;
            state_q   <= pend_en_q ? ST_SETTLE : ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xclk_ctrl.sv
// Randomized and directed checks of xclk_ctrl against a phase-remaining reference model.
module tb_xclk_ctrl;

  localparam int unsigned DDIV = 2;
  localparam int unsigned SC   = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_SETTLE = 3;

  logic       in_clk = 1'b0;
  logic       reset, cfg_valid, cfg_en;
  logic [9:0] cfg_div;
  logic       cfg_ready, outclk, busy, stable;

  always #5 in_clk = ~in_clk;

  xclk_ctrl #(
    .DEFAULT_DIV   (DDIV),
    .DEFAULT_EN    (1'b1),
    .SETTLE_CYCLES (SC)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .outclk    (outclk),
    .busy      (busy),
    .stable    (stable)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: level plus edges left before the next toggle, pending request, rise tally.
  int m_mode, m_div, m_left, m_pdiv, m_rises;
  bit m_level, m_prev, m_en, m_pen;

  function automatic void model_edge(bit rst, bit v, int d, bit e);
    bit acc, rise, safe;
    if (rst) begin
      m_level = 0; m_prev = 0; m_en = 1; m_div = DDIV; m_left = DDIV;
      m_pdiv = 0; m_pen = 0; m_rises = 0; m_mode = M_SETTLE;
      return;
    end
    acc  = v && (m_mode != M_PEND);
    rise = m_level && !m_prev;
    safe = (m_mode == M_PEND) && !m_level && (m_left == 0 || !m_en);
    m_prev = m_level;
    if (safe) begin
      m_div = m_pdiv; m_en = m_pen; m_left = m_pdiv; m_level = m_pen;
      m_rises = 0; m_mode = m_pen ? M_SETTLE : M_IDLE;
    end else begin
      if (m_en) begin
        if (m_left == 0) begin m_level = !m_level; m_left = m_div; end
        else m_left--;
      end
      if (acc) begin
        m_pdiv = d; m_pen = e; m_rises = 0; m_mode = M_PEND;
      end else if (m_mode == M_SETTLE && rise) begin
        if (m_rises < 255) m_rises++;
        if (m_rises >= int'(SC)) m_mode = M_RUN;
      end
    end
  endfunction

  task automatic tick();
    @(posedge in_clk);
    model_edge(reset, cfg_valid, int'(cfg_div), cfg_en);
    @(negedge in_clk);
    check("outclk", 32'(outclk), 32'(m_level));
    check("busy", 32'(busy), 32'(m_mode == M_PEND || m_mode == M_SETTLE));
    check("stable", 32'(stable), 32'(m_mode == M_RUN));
    check("cfg_ready", 32'(cfg_ready), 32'(m_mode != M_PEND));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input int d, input bit e);
    cfg_valid = 1'b1; cfg_div = 10'(d); cfg_en = e;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_run_high(input string tag);
    bit found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_mode == M_RUN && m_level) found = 1;
      else tick();
    end
    if (!found) check(tag, 32'(0), 32'(1));
  endtask

  // Reset, release, and measure first rise, period and stable assertion from release.
  task automatic reset_measure(input string tag);
    int first_rise = 0, second_rise = 0, stable_at = 0;
    bit prev_o = 0;
    reset = 1'b1; cfg_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (outclk && !prev_o) begin
        if (first_rise == 0) first_rise = i;
        else if (second_rise == 0) second_rise = i;
      end
      if (stable && stable_at == 0) stable_at = i;
      prev_o = outclk;
    end
    check({tag, "_first_rise"}, 32'(first_rise), 32'(3));
    check({tag, "_period"}, 32'(second_rise - first_rise), 32'(6));
    check({tag, "_stable_at"}, 32'(stable_at), 32'(22));
  endtask

  initial begin
    int run_len, hi_len, lo_len;
    bit prev_o, seen_rise, done;

    reset = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
    model_edge(1, 0, 0, 0);

    reset_measure("por");

    // Switch to div 0 while high: old high phase and a full low phase complete first.
    wait_run_high("wait_high_a");
    req(0, 1'b1);
    run(30);

    // Disable, then re-enable from IDLE with div 1.
    req(2, 1'b1);
    run(40);
    req(3, 1'b0);
    run(20);
    check("idle_parked", 32'(outclk), 32'(0));
    req(1, 1'b1);
    check("idle_acc_low", 32'(outclk), 32'(0));
    tick();
    check("idle_rise", 32'(outclk), 32'(1));
    run(30);

    // Valid held high across PEND and into SETTLE.
    cfg_valid = 1'b1; cfg_div = 10'd5; cfg_en = 1'b1;
    run(15);
    cfg_valid = 1'b0;
    run(80);

    // Reset while a div 7 request is pending.
    wait_run_high("wait_high_b");
    req(7, 1'b1);
    check("pend_busy", 32'(busy), 32'(1));
    tick();
    reset_measure("rst_pend");

    // Maximum divider.
    req(1023, 1'b1);
    run_len = 0; hi_len = 0; lo_len = 0; prev_o = 0; seen_rise = 0; done = 0;
    for (int i = 0; i < 10000 && !done; i++) begin
      tick();
      if (outclk != prev_o) begin
        if (prev_o && seen_rise && hi_len == 0) hi_len = run_len;
        else if (!prev_o && hi_len != 0 && lo_len == 0) lo_len = run_len;
        if (outclk) seen_rise = 1;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_o = outclk;
      if (stable) done = 1;
    end
    check("max_high_len", 32'(hi_len), 32'(1024));
    check("max_low_len", 32'(lo_len), 32'(1024));
    check("max_stable", 32'(done), 32'(1));

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom % 6) == 0;
      cfg_div   = (($urandom % 8) == 0) ? 10'($urandom % 16) : 10'($urandom % 4);
      cfg_en    = ($urandom % 5) != 0;
      reset     = ($urandom % 400) == 0;
      tick();
    end
    reset = 1'b0; cfg_valid = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
